// File: rtl/instr_decode_stage.sv
// Instruction decode stage: registered, valid/ready handshaked, with a 2-entry
// (main + skid) buffer for full throughput. Decodes the opcode field into a
// type code and per-class control flags, and counts entries handed downstream.
// Optional feature macro: ILLEGAL_TRAP_EN (flag unmapped opcodes, stall the
// input while an illegal entry sits in the output register).
module instr_decode_stage #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPW     = 4,
  parameter int unsigned OP_LSB  = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         out_type,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_is_branch,
  output logic               out_is_jump,
  output logic               out_is_call,
  output logic               out_is_ret,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   dec_count
);

  localparam logic [1:0] TypeR = 2'b00;
  localparam logic [1:0] TypeI = 2'b01;
  localparam logic [1:0] TypeJ = 2'b10;
  localparam logic [1:0] TypeB = 2'b11;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [1:0]         typ;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_jump;
    logic               is_call;
    logic               is_ret;
    logic               illegal;
  } entry_t;

  entry_t         dec;
  entry_t         main_q, main_d;
  entry_t         skid_q, skid_d;
  logic           main_valid_q, main_valid_d;
  logic           skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0] op;
  logic           in_xfer;
  logic           out_xfer;
  logic           main_free;

  // Combinational decode of the incoming word; captured alongside it.
  always_comb begin
    op        = in_instr[OP_LSB +: OPW];
    dec       = '0;
    dec.instr = in_instr;
    dec.typ   = TypeR;
    if ((op >> 4) == '0) begin
      case (op[3:0])
        4'h1, 4'h9, 4'hA, 4'hB: dec.typ = TypeR;
        4'h5: begin
          dec.typ     = TypeR;
          dec.is_load = 1'b1;
        end
        4'h6: begin
          dec.typ      = TypeR;
          dec.is_store = 1'b1;
        end
        4'h2: dec.typ = TypeI;
        4'h3: begin
          dec.typ     = TypeJ;
          dec.is_jump = 1'b1;
        end
        4'h7: begin
          dec.typ     = TypeJ;
          dec.is_call = 1'b1;
        end
        4'h8: begin
          dec.typ    = TypeJ;
          dec.is_ret = 1'b1;
        end
        4'h4: begin
          dec.typ       = TypeB;
          dec.is_branch = 1'b1;
        end
        default: begin
`ifdef ILLEGAL_TRAP_EN
          dec.illegal = 1'b1;
`else
          dec.illegal = 1'b0;
`endif
        end
      endcase
    end else begin
`ifdef ILLEGAL_TRAP_EN
      dec.illegal = 1'b1;
`else
      dec.illegal = 1'b0;
`endif
    end
  end

  // Input readiness depends only on registered state (no path from out_ready).
  always_comb begin
`ifdef ILLEGAL_TRAP_EN
    // Hold off younger work until the trapping entry has left.
    in_ready = ~skid_valid_q & ~(main_valid_q & main_q.illegal);
`else
    in_ready = ~skid_valid_q;
`endif
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_valid_q & out_ready;
  assign main_free = ~main_valid_q | out_ready;

  // Next-state for the main/skid pair; FIFO order, flush wins over everything.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry advances first; a new one (if any) refills skid.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        if (in_xfer) begin
          skid_d = dec;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Main is held by backpressure: park the new entry in skid.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Decoded-entry counter: one per out transfer, wraps, survives flush.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = main_valid_q;
  assign out_instr     = main_q.instr;
  assign out_type      = main_q.typ;
  assign out_is_load   = main_q.is_load;
  assign out_is_store  = main_q.is_store;
  assign out_is_branch = main_q.is_branch;
  assign out_is_jump   = main_q.is_jump;
  assign out_is_call   = main_q.is_call;
  assign out_is_ret    = main_q.is_ret;
  assign out_illegal   = main_q.illegal;
  assign dec_count     = cnt_q;

endmodule
